// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs and data word types.
package y86_pkg;

  typedef logic [3:0]  reg_id_t;
  typedef logic [63:0] word_t;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  localparam reg_id_t RNONE  = 4'hF;
  localparam reg_id_t RSP_ID = 4'h4;

endpackage

// File: rtl/regfile_2r2w.sv
// Register file: two combinational read ports plus a debug port, two write
// ports where port M overrides port E on a shared destination.
module regfile_2r2w #(
  parameter int unsigned NREG = 15,
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      sel_a,
  input  logic [3:0]      sel_b,
  input  logic [3:0]      sel_dbg,
  output logic [XLEN-1:0] val_a,
  output logic [XLEN-1:0] val_b,
  output logic [XLEN-1:0] val_dbg,
  input  logic            we_e,
  input  logic [3:0]      dst_e,
  input  logic [XLEN-1:0] data_e,
  input  logic            we_m,
  input  logic [3:0]      dst_m,
  input  logic [XLEN-1:0] data_m
);
  import y86_pkg::*;

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      // M is assigned last so it wins when dst_e == dst_m (popq %rsp)
      if (we_e && dst_e != RNONE) regs[dst_e] <= data_e;
      if (we_m && dst_m != RNONE) regs[dst_m] <= data_m;
    end
  end

  always_comb begin
    val_a   = (sel_a   == RNONE) ? '0 : regs[sel_a];
    val_b   = (sel_b   == RNONE) ? '0 : regs[sel_b];
    val_dbg = (sel_dbg == RNONE) ? '0 : regs[sel_dbg];
  end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode/write-back stage: source/destination selection, register
// file, and a sticky halt latch that freezes architectural state.
module decode_writeback #(
  parameter int unsigned NREG   = 15,
  parameter int unsigned XLEN   = 64,
  parameter logic [3:0]  RSP_ID = 4'd4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [3:0]      icode,
  input  logic [3:0]      rA,
  input  logic [3:0]      rB,
  input  logic            Cnd,
  input  logic [XLEN-1:0] ValE,
  input  logic [XLEN-1:0] ValM,
  output logic [XLEN-1:0] ValA,
  output logic [XLEN-1:0] ValB,
  output logic [3:0]      dstE,
  output logic [3:0]      dstM,
  output logic            halted,
  output logic            bad_instr,
  input  logic [3:0]      dbg_sel,
  output logic [XLEN-1:0] dbg_val
);
  import y86_pkg::*;

  logic [3:0] src_a;
  logic [3:0] src_b;
  logic       invalid;
  logic       we;

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dstE  = RNONE;
    dstM  = RNONE;
    case (icode)
      I_RRMOVQ: begin src_a = rA; dstE = Cnd ? rB : RNONE; end
      I_IRMOVQ: dstE = rB;
      I_RMMOVQ: begin src_a = rA; src_b = rB; end
      I_MRMOVQ: begin src_b = rB; dstM = rA; end
      I_OPQ:    begin src_a = rA; src_b = rB; dstE = rB; end
      I_CALL:   begin src_b = RSP_ID; dstE = RSP_ID; end
      I_RET:    begin src_a = RSP_ID; src_b = RSP_ID; dstE = RSP_ID; end
      I_PUSHQ:  begin src_a = rA; src_b = RSP_ID; dstE = RSP_ID; end
      I_POPQ:   begin src_a = RSP_ID; src_b = RSP_ID; dstE = RSP_ID; dstM = rA; end
      default:  ;
    endcase
  end

  assign invalid = (icode > 4'(I_POPQ));
  assign we      = instr_valid && !halted && !invalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted    <= 1'b0;
      bad_instr <= 1'b0;
    end else if (instr_valid && !halted) begin
      if (icode == 4'(I_HALT)) begin
        halted <= 1'b1;
      end else if (invalid) begin
        halted    <= 1'b1;
        bad_instr <= 1'b1;
      end
    end
  end

  regfile_2r2w #(
    .NREG(NREG),
    .XLEN(XLEN)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .sel_a   (src_a),
    .sel_b   (src_b),
    .sel_dbg (dbg_sel),
    .val_a   (ValA),
    .val_b   (ValB),
    .val_dbg (dbg_val),
    .we_e    (we),
    .dst_e   (dstE),
    .data_e  (ValE),
    .we_m    (we),
    .dst_m   (dstM),
    .data_m  (ValM)
  );

endmodule

// File: tb/tb_decode_writeback.sv
// Self-checking bench for decode_writeback: vector table plus halt/reset sequences.
module tb_decode_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [3:0]  icode, rA, rB, dbg_sel;
  logic        Cnd;
  logic [63:0] ValE, ValM, ValA, ValB, dbg_val;
  logic [3:0]  dstE, dstM;
  logic        halted, bad_instr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_writeback #(.NREG(15), .XLEN(64), .RSP_ID(4'd4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .icode(icode),
    .rA(rA), .rB(rB), .Cnd(Cnd), .ValE(ValE), .ValM(ValM),
    .ValA(ValA), .ValB(ValB), .dstE(dstE), .dstM(dstM),
    .halted(halted), .bad_instr(bad_instr), .dbg_sel(dbg_sel), .dbg_val(dbg_val)
  );

  typedef struct {
    logic        valid;
    logic [3:0]  ic, ra, rb;
    logic        cnd;
    logic [63:0] ve, vm;
    logic [63:0] ea, eb;
    logic [3:0]  ede, edm;
    logic [3:0]  creg;
    logic [63:0] cval;
  } vec_t;

  typedef struct {
    logic [63:0] a, b;
    logic [3:0]  de, dm;
  } exp_t;

  vec_t v[16];
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic read_reg(input logic [3:0] r, input logic [63:0] exp, input string name);
    dbg_sel = r;
    #1;
    chk(name, dbg_val, exp);
  endtask

  task automatic apply(input vec_t x, input int idx);
    exp_t e;
    @(negedge clk);
    instr_valid = x.valid; icode = x.ic; rA = x.ra; rB = x.rb;
    Cnd = x.cnd; ValE = x.ve; ValM = x.vm;
    sb.push_back('{a: x.ea, b: x.eb, de: x.ede, dm: x.edm});
    #1;
    e = sb.pop_front();
    chk($sformatf("v%0d ValA", idx), ValA, e.a);
    chk($sformatf("v%0d ValB", idx), ValB, e.b);
    chk($sformatf("v%0d dstE", idx), {60'd0, dstE}, {60'd0, e.de});
    chk($sformatf("v%0d dstM", idx), {60'd0, dstM}, {60'd0, e.dm});
    @(posedge clk);
    #1;
    read_reg(x.creg, x.cval, $sformatf("v%0d reg", idx));
  endtask

  localparam logic [63:0] NEG200 = 64'hFFFF_FFFF_FFFF_FF38;

  initial begin
    //        valid ic    ra    rb    cnd ve      vm     ea     eb     ede   edm   creg  cval
    v[0]  = '{1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'd699, 64'd0, 64'd0, 64'd0, 4'h2, 4'hF, 4'h2, 64'd699};
    v[1]  = '{1'b1, 4'h3, 4'hF, 4'h0, 1'b0, 64'd800, 64'd0, 64'd0, 64'd0, 4'h0, 4'hF, 4'h0, 64'd800};
    v[2]  = '{1'b1, 4'h3, 4'hF, 4'h1, 1'b0, 64'd600, 64'd0, 64'd0, 64'd0, 4'h1, 4'hF, 4'h1, 64'd600};
    v[3]  = '{1'b1, 4'h6, 4'h0, 4'h1, 1'b0, NEG200, 64'd0, 64'd800, 64'd600, 4'h1, 4'hF, 4'h1, NEG200};
    v[4]  = '{1'b1, 4'h2, 4'h0, 4'h3, 1'b0, 64'd800, 64'd0, 64'd800, 64'd0, 4'hF, 4'hF, 4'h3, 64'd0};
    v[5]  = '{1'b1, 4'h2, 4'h0, 4'h3, 1'b1, 64'd800, 64'd0, 64'd800, 64'd0, 4'h3, 4'hF, 4'h3, 64'd800};
    v[6]  = '{1'b1, 4'h3, 4'hF, 4'h4, 1'b0, 64'd130, 64'd0, 64'd0, 64'd0, 4'h4, 4'hF, 4'h4, 64'd130};
    v[7]  = '{1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'd138, 64'd55, 64'd130, 64'd130, 4'h4, 4'h4, 4'h4, 64'd55};
    v[8]  = '{1'b1, 4'h3, 4'hF, 4'h4, 1'b0, 64'd550, 64'd0, 64'd0, 64'd0, 4'h4, 4'hF, 4'h4, 64'd550};
    v[9]  = '{1'b1, 4'h8, 4'hF, 4'hF, 1'b0, 64'd542, 64'd0, 64'd0, 64'd550, 4'h4, 4'hF, 4'h4, 64'd542};
    v[10] = '{1'b1, 4'hA, 4'h2, 4'hF, 1'b0, 64'd534, 64'd0, 64'd699, 64'd542, 4'h4, 4'hF, 4'h4, 64'd534};
    v[11] = '{1'b0, 4'h3, 4'hF, 4'h5, 1'b0, 64'd77, 64'd0, 64'd0, 64'd0, 4'h5, 4'hF, 4'h5, 64'd0};
    v[12] = '{1'b1, 4'h5, 4'h6, 4'h2, 1'b0, 64'd0, 64'd99, 64'd0, 64'd699, 4'hF, 4'h6, 4'h6, 64'd99};
    v[13] = '{1'b1, 4'h4, 4'h6, 4'h0, 1'b0, 64'd1, 64'd2, 64'd99, 64'd800, 4'hF, 4'hF, 4'h0, 64'd800};
    v[14] = '{1'b1, 4'h9, 4'hF, 4'hF, 1'b0, 64'd542, 64'd3, 64'd534, 64'd534, 4'h4, 4'hF, 4'h4, 64'd542};
    v[15] = '{1'b1, 4'h3, 4'hF, 4'hF, 1'b0, 64'd5, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 4'hF, 64'd0};

    rst_n = 1'b0; instr_valid = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF;
    Cnd = 1'b0; ValE = '0; ValM = '0; dbg_sel = 4'h0;
    #2;
    chk("reset halted", {63'd0, halted}, 64'd0);
    chk("reset bad_instr", {63'd0, bad_instr}, 64'd0);
    for (int i = 0; i < 15; i++) read_reg(4'(i), 64'd0, $sformatf("reset R%0d", i));
    @(negedge clk);
    rst_n = 1'b1;

    apply(v[0], 0);
    for (int i = 0; i < 15; i++)
      if (i != 2) read_reg(4'(i), 64'd0, $sformatf("irmovq other R%0d", i));
    for (int i = 1; i < 16; i++) apply(v[i], i);
    read_reg(4'h5, 64'd0, "invalid-low R5");
    chk("not halted", {63'd0, halted}, 64'd0);

    // halt, then a blocked write
    @(negedge clk);
    instr_valid = 1'b1; icode = 4'h0; rA = 4'hF; rB = 4'hF;
    @(posedge clk); #1;
    chk("halt halted", {63'd0, halted}, 64'd1);
    chk("halt bad_instr", {63'd0, bad_instr}, 64'd0);
    @(negedge clk);
    icode = 4'h3; rB = 4'h2; ValE = 64'd5;
    @(posedge clk); #1;
    read_reg(4'h2, 64'd699, "halted no write R2");
    icode = 4'h2; rA = 4'h0; rB = 4'h3; #1;
    chk("halted read ValA", ValA, 64'd800);

    // asynchronous reset in the middle of a cycle with a write pending
    @(negedge clk);
    icode = 4'h3; rB = 4'h2; ValE = 64'd5;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst halted", {63'd0, halted}, 64'd0);
    read_reg(4'h2, 64'd0, "async rst R2");
    read_reg(4'h0, 64'd0, "async rst R0");
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n = 1'b1;
    read_reg(4'h2, 64'd0, "post rst R2");

    // invalid icode
    @(negedge clk);
    instr_valid = 1'b1; icode = 4'hC; rA = 4'h2; rB = 4'h2; ValE = 64'd9; ValM = 64'd9;
    #1;
    chk("icode C dstE", {60'd0, dstE}, 64'hF);
    @(posedge clk); #1;
    chk("invalid halted", {63'd0, halted}, 64'd1);
    chk("invalid bad_instr", {63'd0, bad_instr}, 64'd1);
    read_reg(4'h2, 64'd0, "invalid no write R2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
